// File: rtl/tv_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweep engine.
package tv_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    localparam logic [3:0] NAND2_EXPECT = 4'b0111;

    // Number of truth-table rows for an n-input network.
    function automatic int unsigned rows_for(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/tv_sweeper_if.sv
// Sweep control/result bundle between a harness controller and tv_sweeper.
interface tv_sweeper_if
    import tv_sweep_pkg::*;
#(
    parameter int N     = 2,
    parameter int W_OUT = 1
);
    localparam int ROWS = rows_for(N);

    logic                    start;
    logic [W_OUT-1:0]        resp;
    logic [N-1:0]            stim;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic [N:0]              err_count;
    logic [N-1:0]            fail_row;
    logic [ROWS*W_OUT-1:0]   obs_table;

    modport master (
        output start, resp,
        input  stim, busy, done, pass, err_count, fail_row, obs_table
    );

    modport slave (
        input  start, resp,
        output stim, busy, done, pass, err_count, fail_row, obs_table
    );

endinterface

// File: rtl/tv_sweeper_hold_timer.sv
// Per-row hold counter; last marks the final cycle of each row (count == HOLD-1).
module tv_hold_timer #(
    parameter int HOLD = 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic last
);
    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] LAST_VAL = CW'(HOLD - 32'sd1);

    logic [CW-1:0] count_r;

    // Hold counter: cleared on request, wraps after the last cycle of a row.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (en) begin
            if (last) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CW'(1'b1);
            end
        end
    end

    assign last = (count_r == LAST_VAL);

endmodule

// File: rtl/tv_sweeper.sv
// Truth-table sweep engine: drives every input row, captures and checks responses.
// Optional build macro TV_STOP_ON_FAIL_EN ends a sweep at the first mismatching row.
module tv_sweeper
    import tv_sweep_pkg::*;
#(
    parameter int N     = 2,
    parameter int W_OUT = 1,
    parameter int HOLD  = 3,
    parameter logic [rows_for(N)*W_OUT-1:0] EXPECT = (rows_for(N)*W_OUT)'(NAND2_EXPECT)
) (
    input  logic        clock,
    input  logic        reset_n,
    tv_sweeper_if.slave bus
);
    localparam int ROWS = rows_for(N);
    localparam logic [N-1:0] LAST_ROW = {N{1'b1}};

    sweep_state_t            state_r;
    logic [N-1:0]            stim_r;
    logic [N-1:0]            fail_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    pass_r;
    logic [N:0]              err_r;
    logic [ROWS*W_OUT-1:0]   obs_r;

    logic                    row_last_s;
    logic                    start_ok_s;
    logic                    sample_s;
    logic                    mismatch_s;
    logic                    finish_s;
    logic                    timer_clear_s;
    logic                    timer_en_s;
    logic [W_OUT-1:0]        exp_row_s;
    logic [N:0]              err_next_s;

    tv_hold_timer #(.HOLD(HOLD)) u_hold (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clear_s),
        .en      (timer_en_s),
        .last    (row_last_s)
    );

    // Per-cycle decode: start acceptance, sample point, row check and sweep end.
    always_comb begin
        start_ok_s = 1'b0;
        sample_s   = 1'b0;
        timer_en_s = 1'b0;
        case (state_r)
            IDLE, DONE: start_ok_s = bus.start;
            APPLY: begin
                sample_s   = row_last_s;
                timer_en_s = 1'b1;
            end
            default: start_ok_s = 1'b0;
        endcase
        exp_row_s     = EXPECT[stim_r*W_OUT +: W_OUT];
        mismatch_s    = sample_s && (bus.resp != exp_row_s);
        err_next_s    = err_r + {{N{1'b0}}, mismatch_s};
        timer_clear_s = start_ok_s | sample_s;
`ifdef TV_STOP_ON_FAIL_EN
        finish_s      = sample_s && ((stim_r == LAST_ROW) || mismatch_s);
`else
        finish_s      = sample_s && (stim_r == LAST_ROW);
`endif
    end

    // Sweep FSM with all result registers; pass is only meaningful once done is set.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= IDLE;
            stim_r  <= {N{1'b0}};
            fail_r  <= {N{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            err_r   <= {(N+1){1'b0}};
            obs_r   <= {(ROWS*W_OUT){1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start_ok_s) begin
                        state_r <= APPLY;
                        stim_r  <= {N{1'b0}};
                        fail_r  <= {N{1'b0}};
                        err_r   <= {(N+1){1'b0}};
                        obs_r   <= {(ROWS*W_OUT){1'b0}};
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                APPLY: begin
                    if (sample_s) begin
                        obs_r[stim_r*W_OUT +: W_OUT] <= bus.resp;
                        err_r <= err_next_s;
                        if (mismatch_s && (err_r == {(N+1){1'b0}})) begin
                            fail_r <= stim_r;
                        end
                        if (finish_s) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (err_next_s == {(N+1){1'b0}});
                        end else begin
                            stim_r  <= stim_r + N'(1'b1);
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.stim      = stim_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_count = err_r;
    assign bus.fail_row  = fail_r;
    assign bus.obs_table = obs_r;

endmodule

// File: tb/tb_tv_sweeper.sv
// Self-checking bench for tv_sweeper: NAND2 harness (N=2, HOLD=3) and full-adder harness (N=3, W_OUT=2, HOLD=1).
module tb_tv_sweeper;
    import tv_sweep_pkg::*;

    // Full-adder table, {carry,sum} per row, row 7 leftmost: 11 10 10 01 10 01 01 00.
    localparam logic [15:0] FA_EXPECT = 16'hE994;

    typedef struct packed {
        logic [7:0]  stim;
        logic        busy;
        logic        done;
        logic        pass;
        logic [7:0]  err;
        logic [7:0]  fail;
        logic [31:0] obs;
    } view_t;

    logic clk = 1'b0;
    logic reset_n;
    int   net_mode;   // 0 NAND, 1 stuck-at-1, 2 stuck-at-0 (3 = full adder, used by bus3)
    int   total = 0;
    int   passed = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    tv_sweeper_if #(.N(2), .W_OUT(1)) bus2 ();
    tv_sweeper_if #(.N(3), .W_OUT(2)) bus3 ();

    tv_sweeper #(.N(2), .W_OUT(1), .HOLD(3), .EXPECT(NAND2_EXPECT)) dut2 (
        .clock(clk), .reset_n(reset_n), .bus(bus2));
    tv_sweeper #(.N(3), .W_OUT(2), .HOLD(1), .EXPECT(FA_EXPECT)) dut3 (
        .clock(clk), .reset_n(reset_n), .bus(bus3));

    // Networks under test.
    function automatic logic [7:0] net_resp(input int mode, input int r);
        case (mode)
            0:       return (r % 4 == 3) ? 8'd0 : 8'd1;
            1:       return 8'd1;
            2:       return 8'd0;
            3:       return 8'(((r >> 2) & 1) + ((r >> 1) & 1) + (r & 1));
            default: return 8'd0;
        endcase
    endfunction

    logic [7:0] r2_s, r3_s;
    assign r2_s = net_resp(net_mode, int'(bus2.stim));
    assign r3_s = net_resp(3, int'(bus3.stim));
    assign bus2.resp = r2_s[0];
    assign bus3.resp = r3_s[1:0];

    function automatic logic [7:0] tbl_row(input logic [31:0] tbl, input int wout, input int r);
        logic [7:0] v = 8'd0;
        for (int b = 0; b < wout; b++) v[b] = tbl[r*wout + b];
        return v;
    endfunction

    // Expected outputs k edges after the accepting edge, from the sweep rules.
    function automatic view_t model(input int n, input int wout, input int hold,
                                    input logic [31:0] tbl, input int mode,
                                    input int k, input bit started);
        view_t e = '0;
        int rows, end_k, last_k, err, fail;
        logic [7:0] rv, mask;
        if (!started) return e;
        rows = 1 << n;
        mask = 8'((1 << wout) - 1);
        end_k = rows * hold;
`ifdef TV_STOP_ON_FAIL_EN
        for (int r = rows - 1; r >= 0; r--)
            if ((net_resp(mode, r) & mask) != tbl_row(tbl, wout, r)) end_k = (r + 1) * hold;
`endif
        last_k = (k < end_k) ? k : end_k;
        err = 0;
        fail = 0;
        for (int r = 0; r < rows; r++) begin
            if ((r + 1) * hold <= last_k) begin
                rv = net_resp(mode, r) & mask;
                for (int b = 0; b < wout; b++) e.obs[r*wout + b] = rv[b];
                if (rv != tbl_row(tbl, wout, r)) begin
                    if (err == 0) fail = r;
                    err++;
                end
            end
        end
        e.done = (k >= end_k);
        e.busy = !e.done;
        e.stim = e.done ? 8'(end_k / hold - 1) : 8'(k / hold);
        e.pass = e.done && (err == 0);
        e.err  = 8'(err);
        e.fail = 8'(fail);
        return e;
    endfunction

    function automatic view_t snap(input bit on3, input bit pass_rel);
        view_t a;
        if (on3) begin
            a = {8'(bus3.stim), bus3.busy, bus3.done, bus3.pass & pass_rel,
                 8'(bus3.err_count), 8'(bus3.fail_row), 32'(bus3.obs_table)};
        end else begin
            a = {8'(bus2.stim), bus2.busy, bus2.done, bus2.pass & pass_rel,
                 8'(bus2.err_count), 8'(bus2.fail_row), 32'(bus2.obs_table)};
        end
        return a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model bookkeeping at each edge, then a per-cycle comparison of both harnesses.
    bit    st2 = 1'b0, st3 = 1'b0;
    int    k2 = 0, k3 = 0, m2 = 0;
    view_t e2, e3;
    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                st2 = 1'b0; k2 = 0; st3 = 1'b0; k3 = 0;
            end else begin
                e2 = model(2, 1, 3, 32'(NAND2_EXPECT), m2, k2, st2);
                if ((!st2 || e2.done) && bus2.start) begin
                    st2 = 1'b1; k2 = 0; m2 = net_mode;
                end else if (st2 && !e2.done) k2++;
                e3 = model(3, 2, 1, 32'(FA_EXPECT), 3, k3, st3);
                if ((!st3 || e3.done) && bus3.start) begin
                    st3 = 1'b1; k3 = 0;
                end else if (st3 && !e3.done) k3++;
            end
            #1;
            if (chk_en) begin
                e2 = model(2, 1, 3, 32'(NAND2_EXPECT), m2, k2, st2);
                e3 = model(3, 2, 1, 32'(FA_EXPECT), 3, k3, st3);
                check("cyc_nand", 64'(snap(1'b0, !st2 || e2.done)), 64'(e2));
                check("cyc_adder", 64'(snap(1'b1, !st3 || e3.done)), 64'(e3));
            end
        end
    end

    // One sweep from a start pulse; optional start toggling while busy; checks latency.
    task automatic run(input bit on3, input bit toggle, input int want_lat, input string name);
        int lat;
        @(negedge clk);
        if (on3) bus3.start = 1'b1; else bus2.start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus2.start = 1'b0;
        bus3.start = 1'b0;
        while (!(on3 ? bus3.done : bus2.done) && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (toggle && !bus2.done) bus2.start = (lat % 2 == 1);
        end
        bus2.start = 1'b0;
        check(name, 64'(lat), 64'(want_lat));
    endtask

    initial begin
        reset_n = 1'b0;
        bus2.start = 1'b0;
        bus3.start = 1'b0;
        net_mode = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk_en = 1'b1;
        check("rst_state", 64'(snap(1'b0, 1'b1)), 64'd0);

        // 1: correct NAND
        run(1'b0, 1'b0, 13, "t1_lat");
        check("t1_obs", 64'(bus2.obs_table), 64'(4'b0111));
        check("t1_res", 64'({bus2.pass, 3'(bus2.err_count), 2'(bus2.fail_row)}), 64'(6'b1_000_00));

        // 2: stuck-at-1
        net_mode = 1;
        run(1'b0, 1'b0, 13, "t2_lat");
        check("t2_obs", 64'(bus2.obs_table), 64'(4'b1111));
        check("t2_res", 64'({bus2.pass, 3'(bus2.err_count), 2'(bus2.fail_row)}), 64'(6'b0_001_11));

        // 3: stuck-at-0
        net_mode = 2;
`ifdef TV_STOP_ON_FAIL_EN
        run(1'b0, 1'b0, 4, "t3_lat");
        check("t3_res", 64'({bus2.pass, 3'(bus2.err_count), 2'(bus2.fail_row), 2'(bus2.stim)}),
              64'(8'b0_001_00_00));
`else
        run(1'b0, 1'b0, 13, "t3_lat");
        check("t3_res", 64'({bus2.pass, 3'(bus2.err_count), 2'(bus2.fail_row)}), 64'(6'b0_011_00));
`endif
        check("t3_obs", 64'(bus2.obs_table), 64'(4'b0000));

        // 4: reset while row 2 is driven
        net_mode = 0;
        @(negedge clk); bus2.start = 1'b1;
        @(negedge clk); bus2.start = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_row2", 64'(bus2.stim), 64'(2'd2));
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("t4_rst", 64'(snap(1'b0, 1'b1)), 64'd0);
        run(1'b0, 1'b0, 13, "t4_lat");

        // 5: start toggled while busy, then a start from DONE
        run(1'b0, 1'b1, 13, "t5_tog_lat");
        check("t5_pass", 64'(bus2.pass), 64'(1'b1));
        run(1'b0, 1'b0, 13, "t5_redo_lat");

        // start held high: back-to-back sweeps, tracked by the per-cycle model
        @(negedge clk); bus2.start = 1'b1;
        repeat (30) @(negedge clk);
        bus2.start = 1'b0;
        repeat (14) @(negedge clk);
        check("t5_held_done", 64'(bus2.done), 64'(1'b1));

        // 6: full adder, N=3, W_OUT=2, HOLD=1
        run(1'b1, 1'b0, 9, "t6_lat");
        check("t6_obs", 64'(bus3.obs_table), 64'(FA_EXPECT));
        check("t6_res", 64'({bus3.pass, 4'(bus3.err_count)}), 64'(5'b1_0000));

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/tv_sweeper.md
Name: tv_sweeper

Overview:
- Hardware truth-table sweep engine for small combinational networks (NAND and similar).
- Drives every input combination of an N-input device under test in ascending order and holds each row for a fixed number of cycles.
- Captures the device's response for each row, compares it against an expected truth table, and reports pass/fail, error count, first failing row and the full observed table.
- Sits beside the network under test as a self-checking harness; parametrised in input width, output width and hold time.

Parameters:
N, 2, input width of the network under test; rows = 2^N; legal 1..8
W_OUT, 1, output width of the network under test; legal 1..8
HOLD, 3, cycles each row is held before sampling; legal >=1
EXPECT, 4'b0111, expected table of 2^N*W_OUT bits; row r occupies bits [r*W_OUT +: W_OUT]; default is the 2-input NAND

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
start  in  1  begin a sweep; sampled only in IDLE or DONE
resp  in  W_OUT  response of the network under test
stim  out  N  current input row driven to the network
busy  out  1  high while a sweep is running
done  out  1  high from sweep completion until the next accepted start
pass  out  1  valid when done; 1 iff err_count==0
err_count  out  N+1  number of mismatching rows in this sweep
fail_row  out  N  index of the first mismatching row; 0 if none
obs_table  out  2^N*W_OUT  captured responses, same layout as EXPECT

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-low on reset_n. Reset is sampled on the rising edge, so a reset applied in any state, including mid-sweep, takes effect at the next edge.
- Reset values: state=IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, fail_row=0, obs_table=0.
- States: IDLE, APPLY, DONE.
- IDLE:
  - start=1 at an edge: stim<=0, hold counter<=0, err_count<=0, fail_row<=0, obs_table<=0, done<=0, busy<=1, go to APPLY.
- APPLY:
  - stim stays stable for HOLD cycles.
  - At the edge closing the HOLD-th cycle, resp is sampled into obs_table[stim*W_OUT +: W_OUT] and compared with the matching EXPECT slice.
  - On a mismatch, err_count increments. If this is the first mismatch, fail_row<=stim.
  - If stim == 2^N-1: go to DONE, busy<=0, done<=1, pass<=(final err_count==0).
  - Otherwise stim increments and the hold counter clears.
- DONE:
  - Outputs are held; stim keeps the last row applied.
  - start=1 behaves exactly as in IDLE and begins a fresh sweep.
- start while busy is ignored. start held high continuously causes a new sweep immediately after each DONE cycle in which it is sampled.
- Timing: start sampled at edge t.
  - Row r is driven on cycles t+1+r*HOLD through t+(r+1)*HOLD.
  - done rises at the edge t+2^N*HOLD, i.e. it is visible in cycle t+2^N*HOLD+1.
  - For N=2, HOLD=3, done is visible 13 cycles after start.
- Arithmetic and widths:
  - The row counter is N bits and never wraps during a sweep, because the last row exits to DONE.
  - err_count is N+1 bits, so the maximum count 2^N is representable.
  - The hold counter is ceil(log2(HOLD+1)) bits.
- resp is assumed settled before the sample edge. The block adds no synchronisation.

Optional Feature:
- Macro: TV_STOP_ON_FAIL_EN.
- Defined:
  - On the first mismatching row, the block goes directly to DONE with done=1, pass=0, err_count=1, fail_row equal to that row.
  - stim holds the failing row.
  - obs_table rows above the failing row remain 0.
- Undefined: every sweep always covers all 2^N rows.

Decomposition:
- Package tv_sweep_pkg contains:
  - the state encoding (IDLE=2'd0, APPLY=2'd1, DONE=2'd2);
  - the constant NAND2_EXPECT=4'b0111;
  - a function returning rows for a given N.
- Sub-module tv_hold_timer: counter with a clear input and a terminal-count output marking the last cycle of each row, parametrised by HOLD.

Test Plan:
1. Correct NAND DUT (N=2, HOLD=3), one-cycle start pulse -> stim 00,01,10,11 each for 3 cycles; done visible 13 cycles after start; pass=1, err_count=0, fail_row=0, obs_table=4'b0111.
2. DUT stuck-at-1 -> obs_table=4'b1111, err_count=1, fail_row=3, pass=0.
3. DUT stuck-at-0 -> without the macro: err_count=3, fail_row=0, obs_table=0000. With TV_STOP_ON_FAIL_EN: done visible 4 cycles after start, err_count=1, stim=00.
4. reset_n=0 for one edge while row 2 is driven -> next cycle all outputs equal reset values. A following start sweeps again from row 0 with a full 13-cycle latency.
5. start toggled during the sweep -> no effect on the stim sequence. start in DONE -> counters and obs_table cleared and a new sweep begins.
6. N=3, W_OUT=2, HOLD=1, full-adder DUT (sum, carry), EXPECT set to the adder table -> 8 rows; done visible 9 cycles after start; pass=1.
